// File: rtl/conv1d_window_reader.sv
// Read sequencer and sliding-window builder for the Conv1D datapath: fetches Para_Deg-wide
// SRAM words, unpacks them into an ordered sample buffer and emits Kernel_Size-sample windows.
module conv1d_window_reader #(
  parameter int unsigned Data_Width  = 8,
  parameter int unsigned Addr_Width  = 4,
  parameter int unsigned Para_Deg    = 2,
  parameter int unsigned Kernel_Size = 3
) (
  input  logic                             clk,
  input  logic                             Rst,
  input  logic                             Start,
  input  logic [Addr_Width-1:0]            Base_Addr,
  input  logic [Addr_Width:0]              Length,
  output logic                             Busy,
  output logic                             Done,
  output logic                             Chip_Select,
  output logic                             En_Read,
  output logic [Addr_Width-1:0]            Addr_Read,
  input  logic [Para_Deg*Data_Width-1:0]   Read_Data,
  output logic                             Win_Valid,
  input  logic                             Win_Ready,
  output logic [Kernel_Size*Data_Width-1:0] Win_Data
);

  localparam int unsigned Buf_Depth = Kernel_Size - 1 + Para_Deg;
  localparam int unsigned Cnt_W     = $clog2(Buf_Depth + 1);
  localparam int unsigned Len_W     = Addr_Width + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [Data_Width-1:0] buf_q [Buf_Depth];
  logic [Data_Width-1:0] buf_d [Buf_Depth];
  logic [Cnt_W-1:0]      count_q, count_d, cap_n_q, cap_n_d, issue_n;
  logic                  inflight_q, inflight_d;
  logic [Len_W-1:0]      fetched_q, fetched_d, emitted_q, emitted_d, len_q, len_d, remaining;
  logic [Addr_Width-1:0] rd_addr_q, rd_addr_d;
  logic                  issue, win_valid, pop;

  assign remaining = len_q - fetched_q;
  assign issue     = (state_q == StRun) && !inflight_q &&
                     (count_q <= Cnt_W'(Kernel_Size - 1)) && (fetched_q < len_q);
  // Final word of a job may carry fewer valid lanes than Para_Deg.
  assign issue_n   = (remaining >= Len_W'(Para_Deg)) ? Cnt_W'(Para_Deg) : Cnt_W'(remaining);
  assign win_valid = (state_q == StRun) && (count_q >= Cnt_W'(Kernel_Size));
  assign pop       = win_valid && Win_Ready;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    count_d    = count_q;
    cap_n_d    = cap_n_q;
    inflight_d = inflight_q;
    fetched_d  = fetched_q;
    emitted_d  = emitted_q;
    len_d      = len_q;
    rd_addr_d  = rd_addr_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          len_d      = Length;
          rd_addr_d  = Base_Addr;
          fetched_d  = '0;
          emitted_d  = '0;
          count_d    = '0;
          inflight_d = 1'b0;
          state_d    = (Length < Len_W'(Kernel_Size)) ? StDone : StRun;
        end
      end
      StRun: begin
        if (pop) begin
          for (int i = 0; i < int'(Buf_Depth) - 1; i++) buf_d[i] = buf_q[i+1];
          buf_d[Buf_Depth-1] = '0;
          count_d   = count_q - 1'b1;
          emitted_d = emitted_q + 1'b1;
          if (emitted_q == len_q - Len_W'(Kernel_Size)) state_d = StDone;
        end
        // Append after the pop so a same-cycle capture lands behind the shifted entries.
        if (inflight_q) begin
          for (int i = 0; i < int'(Buf_Depth); i++) begin
            for (int j = 0; j < int'(Para_Deg); j++) begin
              if (j < int'(cap_n_q) && i == int'(count_d) + j) begin
                buf_d[i] = Read_Data[j*Data_Width +: Data_Width];
              end
            end
          end
          count_d    = count_d + cap_n_q;
          inflight_d = 1'b0;
        end
        if (issue) begin
          rd_addr_d  = rd_addr_q + Addr_Width'(Para_Deg);
          fetched_d  = fetched_q + Len_W'(issue_n);
          cap_n_d    = issue_n;
          inflight_d = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q    <= StIdle;
      for (int i = 0; i < int'(Buf_Depth); i++) buf_q[i] <= '0;
      count_q    <= '0;
      cap_n_q    <= '0;
      inflight_q <= 1'b0;
      fetched_q  <= '0;
      emitted_q  <= '0;
      len_q      <= '0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      count_q    <= count_d;
      cap_n_q    <= cap_n_d;
      inflight_q <= inflight_d;
      fetched_q  <= fetched_d;
      emitted_q  <= emitted_d;
      len_q      <= len_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign Busy        = (state_q == StRun);
  assign Done        = (state_q == StDone);
  assign En_Read     = issue;
  assign Chip_Select = issue;
  assign Addr_Read   = issue ? rd_addr_q : '0;
  assign Win_Valid   = win_valid;

  always_comb begin
    Win_Data = '0;
    for (int k = 0; k < int'(Kernel_Size); k++) Win_Data[k*Data_Width +: Data_Width] = buf_q[k];
  end

endmodule

// File: tb/tb_conv1d_window_reader.sv
// Directed bench for conv1d_window_reader with a registered-read SRAM holding mem[a] = a + 1.
module tb_conv1d_window_reader;

  logic        clk = 1'b0;
  logic        Rst, Start, Win_Ready;
  logic [3:0]  Base_Addr;
  logic [4:0]  Length;
  logic        Busy, Done, Chip_Select, En_Read, Win_Valid;
  logic [3:0]  Addr_Read;
  logic [15:0] Read_Data = '0;
  logic [23:0] Win_Data;

  int checks = 0;
  int passed = 0;
  int       exp_addr[$];
  logic [23:0] exp_win[$];

  conv1d_window_reader dut (
    .clk        (clk),
    .Rst        (Rst),
    .Start      (Start),
    .Base_Addr  (Base_Addr),
    .Length     (Length),
    .Busy       (Busy),
    .Done       (Done),
    .Chip_Select(Chip_Select),
    .En_Read    (En_Read),
    .Addr_Read  (Addr_Read),
    .Read_Data  (Read_Data),
    .Win_Valid  (Win_Valid),
    .Win_Ready  (Win_Ready),
    .Win_Data   (Win_Data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_val(input logic [3:0] a);
    return {4'b0, a} + 8'd1;
  endfunction

  always @(posedge clk) begin
    if (Chip_Select && En_Read) Read_Data <= {mem_val(Addr_Read + 4'd1), mem_val(Addr_Read)};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_job(input string nm, input logic [3:0] base, input logic [4:0] len,
                         input int stall, input int exp_first, input int exp_done);
    int cyc, ri, wi, first_v, stall_left;
    bit done_seen;
    ri = 0; wi = 0; first_v = -1; stall_left = stall; done_seen = 1'b0;
    Base_Addr = base; Length = len; Win_Ready = 1'b1; Start = 1'b1;
    step();
    Start = 1'b0;
    cyc = 1;
    chk({nm, " busy c1"}, 32'(Busy), 32'(exp_first >= 0));
    while (cyc < 100) begin
      if (En_Read) begin
        chk({nm, " cs"}, 32'(Chip_Select), 1);
        if (ri < exp_addr.size()) chk($sformatf("%s addr%0d", nm, ri), 32'(Addr_Read), exp_addr[ri]);
        else chk({nm, " extra read"}, 32'(En_Read), 0);
        ri++;
      end
      if (Win_Valid) begin
        if (first_v < 0) first_v = cyc;
        if (wi < exp_win.size()) chk($sformatf("%s win%0d", nm, wi), 32'(Win_Data), 32'(exp_win[wi]));
        else chk({nm, " extra win"}, 32'(Win_Valid), 0);
        if (stall_left > 0) begin
          Win_Ready = 1'b0;
          chk({nm, " no read in stall"}, 32'(En_Read), 0);
          stall_left--;
        end else begin
          Win_Ready = 1'b1;
          wi++;
        end
      end else begin
        Win_Ready = 1'b1;
      end
      if (Done) begin
        done_seen = 1'b1;
        break;
      end
      step();
      cyc++;
    end
    chk({nm, " done seen"}, 32'(done_seen), 1);
    chk({nm, " done cycle"}, cyc, exp_done);
    chk({nm, " first valid"}, first_v, exp_first);
    chk({nm, " reads"}, ri, exp_addr.size());
    chk({nm, " windows"}, wi, exp_win.size());
    step();
    chk({nm, " done pulse"}, 32'(Done), 0);
    chk({nm, " idle busy"}, 32'(Busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 1'b1; Start = 1'b0; Base_Addr = '0; Length = '0; Win_Ready = 1'b1;
    step(); step();
    chk("rst busy", 32'(Busy), 0);
    chk("rst done", 32'(Done), 0);
    chk("rst cs", 32'(Chip_Select), 0);
    chk("rst en", 32'(En_Read), 0);
    chk("rst addr", 32'(Addr_Read), 0);
    chk("rst valid", 32'(Win_Valid), 0);
    chk("rst data", 32'(Win_Data), 0);
    Rst = 1'b0;
    step();

    exp_addr = '{0, 2, 4};
    exp_win  = '{24'h030201, 24'h040302, 24'h050403, 24'h060504};
    run_job("len6", 4'd0, 5'd6, 0, 5, 11);
    run_job("stall", 4'd0, 5'd6, 5, 5, 16);

    exp_win = '{24'h030201, 24'h040302, 24'h050403};
    run_job("len5", 4'd0, 5'd5, 0, 5, 10);

    exp_addr = '{14, 0, 2};
    exp_win  = '{24'h01100f, 24'h020110, 24'h030201};
    run_job("wrap", 4'd14, 5'd5, 0, 5, 10);

    exp_addr = {};
    exp_win  = {};
    run_job("len2", 4'd0, 5'd2, 0, -1, 1);

    // Reset lands in the capture cycle of the second read.
    Base_Addr = 4'd0; Length = 5'd6; Start = 1'b1;
    step();
    Start = 1'b0;
    chk("mid addr0", 32'(Addr_Read), 0);
    step(); step();
    chk("mid addr1", 32'(Addr_Read), 2);
    step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("mid busy", 32'(Busy), 0);
    chk("mid done", 32'(Done), 0);
    chk("mid en", 32'(En_Read | Chip_Select), 0);
    chk("mid addr", 32'(Addr_Read), 0);
    chk("mid valid", 32'(Win_Valid), 0);
    chk("mid data", 32'(Win_Data), 0);
    step();
    chk("mid idle valid", 32'(Win_Valid), 0);
    chk("mid idle en", 32'(En_Read), 0);

    exp_addr = '{0, 2, 4};
    exp_win  = '{24'h030201, 24'h040302, 24'h050403, 24'h060504};
    run_job("after rst", 4'd0, 5'd6, 0, 5, 11);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
